// File: rtl/seq_detect_param_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The failure table is derived from the pattern, so no per-pattern state list is hand-written.
package seq_det_pkg;

   localparam int LEN_MIN = 2;
   localparam int LEN_MAX = 16;
   localparam int IDX_W   = 5;

   typedef logic [IDX_W-1:0]   idx_t;
   typedef idx_t [LEN_MAX:0]   fail_t;
   typedef logic [LEN_MAX-1:0] pat_t;

   // Bit i of the pattern in arrival order (i=0 is the first bit received).
   function automatic logic pat_bit(pat_t p, int len, int i);
      logic b;
      b = 1'b0;
      for (int k = 0; k < LEN_MAX; k++)
         if (k == len - 1 - i) b = p[k];
      return b;
   endfunction

   // KMP failure table: f[k] is the longest proper prefix of the first k
   // pattern bits that is also a suffix of them.
   function automatic fail_t fail_tbl(pat_t p, int len);
      fail_t f;
      int    j;
      f = '0;
      for (int k = 2; k <= LEN_MAX; k++) begin
         if (k <= len) begin
            j = int'(f[k-1]);
            for (int n = 0; n < LEN_MAX; n++)
               if (j > 0 && pat_bit(p, len, k-1) != pat_bit(p, len, j))
                  j = int'(f[j]);
            if (pat_bit(p, len, k-1) == pat_bit(p, len, j)) j++;
            f[k] = idx_t'(j);
         end
      end
      return f;
   endfunction

   // Prefix length after accepting din from prefix length q.
   // A return value equal to len means the full pattern has been seen.
   function automatic idx_t next_q(idx_t q, logic din, pat_t p, int len, fail_t f);
      int   j;
      idx_t r;
      logic done;
      j    = int'(q);
      r    = '0;
      done = 1'b0;
      for (int n = 0; n <= LEN_MAX; n++) begin
         if (!done) begin
            if (din == pat_bit(p, len, j)) begin
               r    = idx_t'(j + 1);
               done = 1'b1;
            end else if (j == 0) begin
               r    = '0;
               done = 1'b1;
            end else begin
               j = int'(f[j]);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream/result bundle of the pattern detector.
// match_cnt exists only when SEQ_DET_CNT_EN is defined.
interface seq_detect_param_if #(
   parameter int CNT_W = 8
);
   logic din;
   logic din_vld;
   logic overlap;
   logic clr;
   logic alarm;
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detect_param_if: CNT_W must be at least 1");
   end

`ifdef SEQ_DET_CNT_EN
   modport master (output din, din_vld, overlap, clr, input alarm, match_cnt);
   modport slave  (input din, din_vld, overlap, clr, output alarm, match_cnt);
`else
   modport master (output din, din_vld, overlap, clr, input alarm);
   modport slave  (input din, din_vld, overlap, clr, output alarm);
`endif
endinterface

// File: rtl/seq_detect_param_sat_cnt.sv
// Generic saturating up-counter; clear beats increment.
module seq_det_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count up on inc, hold at all-ones, clear synchronously on clr.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a one-cycle registered alarm.
// Optional match counter enabled by defining SEQ_DET_CNT_EN.
//
//  q        | meaning
//  0        | no pattern prefix matched
//  1..LEN-1 | last q valid bits equal the first q pattern bits
//
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1101,
   parameter int             CNT_W   = 8
) (
   input logic              clk,
   input logic              n_rst,
   seq_detect_param_if.slave bus
);

   if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
      $error("seq_detect_param: LEN must be within 2..16");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W must be at least 1");
   end

   localparam int             QW      = $clog2(LEN);
   localparam pat_t           PAT_EXT = pat_t'(PATTERN);
   localparam fail_t          FAIL_T  = fail_tbl(PAT_EXT, LEN);
   localparam logic [QW-1:0]  Q_OVL   = QW'(FAIL_T[LEN]);

   logic [QW-1:0] q;
   idx_t          nq;
   logic          hit;

   // Next prefix length for the current bit, and whether it completes the pattern.
   always_comb begin
      nq  = next_q(idx_t'(q), bus.din, PAT_EXT, LEN, FAIL_T);
      hit = (nq == idx_t'(LEN));
   end

   // Matcher state and registered alarm; clr outranks a valid bit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q         <= '0;
         bus.alarm <= 1'b0;
      end else if (bus.clr) begin
         q         <= '0;
         bus.alarm <= 1'b0;
      end else if (bus.din_vld) begin
         bus.alarm <= hit;
         if (hit)
            q <= bus.overlap ? Q_OVL : '0;
         else
            q <= QW'(nq);
      end else begin
         bus.alarm <= 1'b0;
      end
   end

`ifdef SEQ_DET_CNT_EN
   seq_det_sat_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .inc   (bus.din_vld & hit),
      .clr   (bus.clr),
      .cnt   (bus.match_cnt)
   );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus random stream,
// scored against a sliding-window reference model.
module tb_seq_detect_param;

   localparam int           LEN     = 4;
   localparam logic [3:0]   PAT     = 4'b1101;
   localparam int           CNT_W   = 8;
   localparam int           CNT_MAX = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   int   cyc   = 0;

   int   pass_cnt    = 0;
   int   chk_cnt     = 0;
   int   alarms_seen = 0;
   int   exp_q[$];
   bit   hist[$];
   int   model_cnt   = 0;

   seq_detect_param_if #(.CNT_W(CNT_W)) bus ();

   seq_detect_param #(
      .LEN     (LEN),
      .PATTERN (PAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

`ifdef SEQ_DET_CNT_EN
   logic n_rst2 = 1'b1;
   seq_detect_param_if #(.CNT_W(2)) bus2 ();
   seq_detect_param #(
      .LEN     (3),
      .PATTERN (3'b111),
      .CNT_W   (2)
   ) dut2 (
      .clk   (clk),
      .n_rst (n_rst2),
      .bus   (bus2)
   );
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      chk_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Does the window of the last LEN valid bits spell the pattern?
   function automatic bit tail_match();
      int base;
      if (hist.size() < LEN) return 1'b0;
      base = hist.size() - LEN;
      for (int i = 0; i < LEN; i++)
         if (hist[base + i] != PAT[LEN-1-i]) return 1'b0;
      return 1'b1;
   endfunction

   // Drive one cycle of inputs and advance the reference model.
   task automatic step(input bit d, input bit v, input bit ov, input bit c, input bit cnt_chk = 1'b0);
      @(posedge clk);
      #1;
`ifdef SEQ_DET_CNT_EN
      if (cnt_chk) check("match_cnt_rand", bus.match_cnt, model_cnt);
`endif
      bus.din     = d;
      bus.din_vld = v;
      bus.overlap = ov;
      bus.clr     = c;
      if (c) begin
         hist.delete();
         model_cnt = 0;
      end else if (v) begin
         hist.push_back(d);
         if (hist.size() > LEN) void'(hist.pop_front());
         if (tail_match()) begin
            exp_q.push_back(cyc + 1);
            if (model_cnt < CNT_MAX) model_cnt++;
            if (!ov) hist.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
   endtask

   task automatic run_bits(input bit ov, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) step(bits[n-1-i], 1'b1, ov, 1'b0);
   endtask

   task automatic scen(input string name, input bit ov, input logic [15:0] bits,
                       input int n, input int exp_alarms);
      int start;
      step(1'b0, 1'b0, ov, 1'b1);
      start = alarms_seen;
      run_bits(ov, bits, n);
      idle(2);
      check(name, alarms_seen - start, exp_alarms);
`ifdef SEQ_DET_CNT_EN
      check({name, "_cnt"}, bus.match_cnt, exp_alarms);
`endif
   endtask

   // Monitor: every alarm must match the oldest predicted alarm cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
         chk_cnt++;
         $display("FAIL missing_alarm: got none at cycle %0d, required alarm", exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (bus.alarm === 1'b1) begin
         alarms_seen++;
         chk_cnt++;
         if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            pass_cnt++;
            void'(exp_q.pop_front());
         end else begin
            $display("FAIL unexpected_alarm: got alarm=1 at cycle %0d, required 0", cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      bus.din     = 1'b0;
      bus.din_vld = 1'b0;
      bus.overlap = 1'b0;
      bus.clr     = 1'b0;
`ifdef SEQ_DET_CNT_EN
      bus2.din     = 1'b0;
      bus2.din_vld = 1'b0;
      bus2.overlap = 1'b1;
      bus2.clr     = 1'b0;
`endif
      #2;
      n_rst = 1'b0;
`ifdef SEQ_DET_CNT_EN
      n_rst2 = 1'b0;
`endif
      #1;
      check("reset_alarm", bus.alarm, 0);
`ifdef SEQ_DET_CNT_EN
      check("reset_cnt", bus.match_cnt, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
`ifdef SEQ_DET_CNT_EN
      n_rst2 = 1'b1;
`endif

      scen("ovl0_1101101", 1'b0, 16'b1101101, 7, 1);
      scen("ovl1_1101101", 1'b1, 16'b1101101, 7, 2);
      scen("fallback_11101", 1'b0, 16'b11101, 5, 1);

      // valid bits separated by three idle cycles with random din
      step(1'b0, 1'b0, 1'b0, 1'b1);
      start = alarms_seen;
      for (int i = 0; i < 4; i++) begin
         step(PAT[3-i], 1'b1, 1'b0, 1'b0);
         idle(3);
      end
      check("gaps_1101", alarms_seen - start, 1);

      // clr on the final bit suppresses the match and empties the prefix
      step(1'b0, 1'b0, 1'b0, 1'b1);
      start = alarms_seen;
      run_bits(1'b0, 16'b110, 3);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      idle(2);
      check("clr_on_last", alarms_seen - start, 0);
      run_bits(1'b0, 16'b1101, 4);
      idle(2);
      check("after_clr", alarms_seen - start, 1);

      // async reset mid-prefix discards it
      step(1'b0, 1'b0, 1'b0, 1'b1);
      run_bits(1'b0, 16'b110, 3);
      idle(1);
      @(posedge clk);
      #1;
      n_rst = 1'b0;
      hist.delete();
      model_cnt = 0;
      #1;
      check("async_rst_alarm", bus.alarm, 0);
`ifdef SEQ_DET_CNT_EN
      check("async_rst_cnt", bus.match_cnt, 0);
`endif
      #10;
      n_rst = 1'b1;
      start = alarms_seen;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("rst_discard", alarms_seen - start, 0);
      run_bits(1'b1, 16'b101, 3);
      idle(2);
      check("rst_restart", alarms_seen - start, 1);

      // random stream, overlap and clr toggled freely
      for (int i = 0; i < 3000; i++)
         step(1'($urandom), ($urandom_range(9) < 7), 1'($urandom),
              ($urandom_range(39) == 0), (i % 50) == 49);
      idle(3);
      check("pending_alarms", exp_q.size(), 0);

`ifdef SEQ_DET_CNT_EN
      // LEN=3 all-ones pattern: back-to-back alarms and a 2-bit saturating count
      for (int i = 0; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (i > 0) check($sformatf("ones_alarm_%0d", i), bus2.alarm, (i - 1 >= 2) ? 1 : 0);
         bus2.din     = 1'b1;
         bus2.din_vld = (i < 8) ? 1'b1 : 1'b0;
      end
      check("ones_cnt_sat", bus2.match_cnt, 3);
      n_rst2 = 1'b0;
      #1;
      check("ones_rst_alarm", bus2.alarm, 0);
      check("ones_rst_cnt", bus2.match_cnt, 0);
      #10;
      n_rst2 = 1'b1;
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; generalises the fixed 4-bit sequence finder.
- Detects a compile-time pattern of any length on a 1-bit stream qualified by a valid strobe.
- Supports runtime overlap or non-overlap matching and gives a one-cycle registered alarm per match.
- Sits between a serial deserialiser or line monitor and the control/interrupt logic.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, LEN-bit pattern. PATTERN[LEN-1] is the first bit received and PATTERN[0] is the last.
- CNT_W, 8, width of the match counter (exists only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- din  in  1  serial data bit.
- din_vld  in  1  din is sampled only on cycles where din_vld=1.
- overlap  in  1  1 = overlapping matches allowed; 0 = matching restarts from empty after each match.
- clr  in  1  synchronous clear of matcher state (and counter, if present).
- alarm  out  1  one-cycle pulse, registered.
- match_cnt  out  CNT_W  saturating match count (only with SEQ_DET_CNT_EN).

Behaviour:
- State: matched-prefix length q, range 0..LEN-1, width $clog2(LEN).
- Reset values: n_rst=0 forces q=0, alarm=0, match_cnt=0 asynchronously.
- Transition, applied only when din_vld=1:
  - Define bit e = PATTERN[LEN-1-q].
  - If din==e and q<LEN-1: q <= q+1.
  - If din==e and q==LEN-1: this is a match. alarm <= 1. q <= overlap ? F[LEN] : 0.
  - If din!=e: q <= the longest proper prefix of PATTERN that is a suffix of the received bits (KMP fallback through F, then test din).
- F is the prefix/failure table, computed at elaboration from PATTERN. There is no hand-coded state list.
- din_vld=0: q holds and alarm <= 0.
- Latency: alarm is high in the cycle immediately after the clock edge that sampled the last pattern bit. It is high for exactly 1 cycle. Back-to-back matches can pulse on consecutive valid cycles only when F[LEN]==LEN-1 (e.g. an all-ones pattern).
- clr=1 (synchronous):
  - q <= 0, alarm <= 0; match_cnt <= 0 if present.
  - clr has priority over din_vld.
  - The din sampled in the clr cycle is discarded.
- overlap may change at any cycle. It is used only at the match edge and does not affect q otherwise.
- Async reset mid-stream discards any partial prefix. Detection restarts at the first valid bit after release.
- Illegal LEN (outside 2..16) is an elaboration error.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each match edge.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared by clr and by n_rst.
  - If a clr and a match fall in the same cycle, clr wins and the result is 0.
- Undefined: the match_cnt port and its counter logic are absent, and CNT_W is unused.

Decomposition:
- Package seq_det_pkg:
  - Constants LEN_MIN=2 and LEN_MAX=16.
  - Function fail_tbl(pattern, len) returning the KMP failure array.
  - Function next_q(q, din, pattern, fail) used by the next-state logic.
- Sub-module seq_det_sat_cnt: generic saturating counter with inc, clr, width parameter. It is instantiated under SEQ_DET_CNT_EN.

Test Plan:
- Defaults, overlap=0, valid bits 1,1,0,1,1,0,1 → alarm pulses once, 1 cycle after the 4th bit; the 7th bit does not produce a match (state restarted to 0 after the match). match_cnt=1.
- Defaults, overlap=1, same stream → alarm pulses after the 4th and 7th bits (shared "1"). match_cnt=2.
- Defaults, stream 1,1,1,0,1 → exactly one pulse after the 5th bit, confirming the fallback from q=2 on a repeated 1.
- Gaps: stream 1,1,0,1 with din_vld=0 for 3 cycles between each valid bit (din toggling randomly during the gaps) → one pulse, only after the last valid bit. alarm is 0 during the gaps.
- clr asserted in the cycle the 4th bit (1) is valid → no alarm and q=0. Then 1,1,0,1 → alarm.
- LEN=3, PATTERN=3'b111, overlap=1, CNT_W=2, SEQ_DET_CNT_EN defined, eight consecutive 1s → alarm on bits 3..8 (6 pulses); match_cnt saturates at 3. Assert n_rst mid-stream → alarm=0 and match_cnt=0 immediately.
